// File: rtl/imm_gen_pipe.sv
// imm_gen_pipe: immediate generator with prefix support and a one-stage
// registered valid/ready output. A prefix instruction parks 12 upper bits
// that are combined with the low nibble of the next non-prefix instruction.
module imm_gen_pipe #(
  parameter int          DATA_W     = 16,
  parameter bit          PREFIX_EN  = 1'b1,
  parameter logic [3:0]  PREFIX_OPC = 4'hF
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              flush,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [15:0]       instr,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [DATA_W-1:0] imm,
  output logic [1:0]        imm_class,
  output logic              out_prefixed,
  output logic              err_pfx_overwrite
);

  typedef enum logic {NO_PFX = 1'b0, PFX_PENDING = 1'b1} state_e;

  state_e              state_q, state_d;
  logic [11:0]         pfx_q, pfx_d;
  logic                out_valid_q, out_valid_d;
  logic [DATA_W-1:0]   imm_q, imm_d;
  logic [1:0]          class_q, class_d;
  logic                prefixed_q, prefixed_d;
  logic                err_q, err_d;

  logic                accept, is_pfx;
  logic [1:0]          opc_class;
  logic [DATA_W-1:0]   plain_imm, pfx_imm;
  logic [15:0]         pfx_val;

  // The output register can take a new word whenever it is empty or draining.
  assign in_ready = !out_valid_q | out_ready;
  // A flush kills whatever instruction is presented alongside it.
  assign accept   = in_valid & in_ready & ~flush;
  assign is_pfx   = PREFIX_EN && (instr[15:12] == PREFIX_OPC);

  // Opcode class and the non-prefixed extension of the instruction field.
  always_comb begin
    opc_class = 2'b00;
    plain_imm = '0;
    if (!instr[15]) begin
      opc_class = 2'b00;
      plain_imm = DATA_W'(instr[3:0]);
    end else if (instr[14:13] == 2'b00) begin
      opc_class = 2'b01;
      plain_imm = DATA_W'($signed(instr[3:0]));
    end else if (instr[14:13] == 2'b01) begin
      opc_class = 2'b10;
      plain_imm = DATA_W'($signed(instr[7:0]));
    end else begin
      opc_class = 2'b11;
      plain_imm = DATA_W'($signed(instr[8:0]));
    end
  end

  // Prefixed value: compute class zero-extends, every other class sign-extends.
  assign pfx_val = {pfx_q, instr[3:0]};
  assign pfx_imm = (opc_class == 2'b00) ? DATA_W'(pfx_val)
                                        : DATA_W'($signed(pfx_val));

  // FSM state register.
  always_ff @(posedge clk) begin
    if (rst) state_q <= NO_PFX;
    else     state_q <= state_d;
  end

  // FSM next state: any accepted prefix lands in PFX_PENDING, anything else leaves it.
  always_comb begin
    state_d = state_q;
    if (flush)       state_d = NO_PFX;
    else if (accept) state_d = is_pfx ? PFX_PENDING : NO_PFX;
  end

  // FSM outputs: next values for the output stage and the prefix register.
  always_comb begin
    out_valid_d = out_valid_q & ~out_ready;
    imm_d       = imm_q;
    class_d     = class_q;
    prefixed_d  = prefixed_q;
    pfx_d       = pfx_q;
    err_d       = 1'b0;
    if (flush) begin
      out_valid_d = 1'b0;
      prefixed_d  = 1'b0;
    end else if (accept) begin
      if (is_pfx) begin
        // A prefix produces no output; the slot simply drains.
        pfx_d = instr[11:0];
        err_d = (state_q == PFX_PENDING);
      end else begin
        out_valid_d = 1'b1;
        imm_d       = (state_q == PFX_PENDING) ? pfx_imm : plain_imm;
        class_d     = opc_class;
        prefixed_d  = (state_q == PFX_PENDING);
      end
    end
  end

  // Output stage and prefix register.
  always_ff @(posedge clk) begin
    if (rst) begin
      out_valid_q <= 1'b0;
      imm_q       <= '0;
      class_q     <= 2'b00;
      prefixed_q  <= 1'b0;
      pfx_q       <= '0;
      err_q       <= 1'b0;
    end else begin
      out_valid_q <= out_valid_d;
      imm_q       <= imm_d;
      class_q     <= class_d;
      prefixed_q  <= prefixed_d;
      pfx_q       <= pfx_d;
      err_q       <= err_d;
    end
  end

  assign out_valid         = out_valid_q;
  assign imm               = imm_q;
  assign imm_class         = class_q;
  assign out_prefixed      = prefixed_q;
  assign err_pfx_overwrite = err_q;

endmodule

// File: tb/tb_imm_gen_pipe.sv
// Directed bench for imm_gen_pipe: a 16-bit and a 32-bit instance share stimulus.
module tb_imm_gen_pipe;

  logic        clk = 1'b0;
  logic        rst, flush, in_valid, out_ready;
  logic [15:0] instr;

  logic        rdy16, vld16, pfx16, err16;
  logic [15:0] imm16;
  logic [1:0]  cls16;
  logic        rdy32, vld32, pfx32, err32;
  logic [31:0] imm32;
  logic [1:0]  cls32;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  imm_gen_pipe #(.DATA_W(16)) dut16 (
    .clk(clk), .rst(rst), .flush(flush), .in_valid(in_valid), .in_ready(rdy16),
    .instr(instr), .out_valid(vld16), .out_ready(out_ready), .imm(imm16),
    .imm_class(cls16), .out_prefixed(pfx16), .err_pfx_overwrite(err16));

  imm_gen_pipe #(.DATA_W(32)) dut32 (
    .clk(clk), .rst(rst), .flush(flush), .in_valid(in_valid), .in_ready(rdy32),
    .instr(instr), .out_valid(vld32), .out_ready(out_ready), .imm(imm32),
    .imm_class(cls32), .out_prefixed(pfx32), .err_pfx_overwrite(err32));

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  task automatic drive(input logic v, input logic [15:0] i, input logic ordy, input logic fl);
    in_valid = v; instr = i; out_ready = ordy; flush = fl;
    #1;
  endtask

  task automatic tick();
    @(posedge clk); #1;
  endtask

  // Drive one accepted-or-not word, clock it, and check both instances' output.
  task automatic expect_out(input string tag, input logic [15:0] i,
                            input logic [15:0] e16, input logic [31:0] e32,
                            input logic [1:0] cls, input logic pf);
    drive(1'b1, i, 1'b1, 1'b0);
    tick();
    chk({tag, ".vld"},  {31'd0, vld16}, 32'd1);
    chk({tag, ".imm16"}, {16'd0, imm16}, {16'd0, e16});
    chk({tag, ".imm32"}, imm32, e32);
    chk({tag, ".cls"},  {30'd0, cls16}, {30'd0, cls});
    chk({tag, ".cls32"}, {30'd0, cls32}, {30'd0, cls});
    chk({tag, ".pfx"},  {31'd0, pfx16}, {31'd0, pf});
  endtask

  task automatic expect_none(input string tag, input logic [15:0] i);
    drive(1'b1, i, 1'b1, 1'b0);
    tick();
    chk({tag, ".novld"}, {31'd0, vld16}, 32'd0);
    chk({tag, ".novld32"}, {31'd0, vld32}, 32'd0);
  endtask

  initial begin
    rst = 1'b1;
    drive(1'b1, 16'h0A35, 1'b0, 1'b0);
    tick(); tick();
    chk("rst.vld", {31'd0, vld16}, 32'd0);
    chk("rst.imm", {16'd0, imm16}, 32'd0);
    chk("rst.cls", {30'd0, cls16}, 32'd0);
    chk("rst.pfx", {31'd0, pfx16}, 32'd0);
    chk("rst.err", {31'd0, err16}, 32'd0);
    chk("rst.rdy", {31'd0, rdy16}, 32'd1);
    rst = 1'b0;

    // Plain decode, back to back
    expect_out("p0", 16'h0A35, 16'h0005, 32'h0000_0005, 2'b00, 1'b0);
    expect_out("p1", 16'h800F, 16'hFFFF, 32'hFFFF_FFFF, 2'b01, 1'b0);
    expect_out("p2", 16'hA080, 16'hFF80, 32'hFFFF_FF80, 2'b10, 1'b0);
    expect_out("p3", 16'hC1FF, 16'hFFFF, 32'hFFFF_FFFF, 2'b11, 1'b0);
    expect_out("p4", 16'hC0FF, 16'h00FF, 32'h0000_00FF, 2'b11, 1'b0);

    // Single prefix
    expect_none("pf0", 16'hF123);
    expect_out("pf1", 16'h8005, 16'h1235, 32'h0000_1235, 2'b01, 1'b1);
    expect_out("pf2", 16'h8005, 16'h0005, 32'h0000_0005, 2'b01, 1'b0);

    // Prefix width: compute zero-extends, control sign-extends from bit 15
    expect_none("w0", 16'hFABC);
    expect_out("w1", 16'h0007, 16'hABC7, 32'h0000_ABC7, 2'b00, 1'b1);
    expect_none("w2", 16'hFABC);
    expect_out("w3", 16'hC003, 16'hABC3, 32'hFFFF_ABC3, 2'b11, 1'b1);

    // Double prefix: overwrite pulse lasts exactly one cycle
    expect_none("d0", 16'hF111);
    chk("d0.err", {31'd0, err16}, 32'd0);
    expect_none("d1", 16'hF222);
    chk("d1.err", {31'd0, err16}, 32'd1);
    chk("d1.err32", {31'd0, err32}, 32'd1);
    expect_out("d2", 16'h8003, 16'h2223, 32'h0000_2223, 2'b01, 1'b1);
    chk("d2.err", {31'd0, err16}, 32'd0);

    // Backpressure: held output, no accept until out_ready returns
    expect_out("b0", 16'hA080, 16'hFF80, 32'hFFFF_FF80, 2'b10, 1'b0);
    drive(1'b1, 16'h0A35, 1'b0, 1'b0);
    for (int k = 0; k < 3; k++) begin
      chk("b.rdy", {31'd0, rdy16}, 32'd0);
      tick();
      chk("b.vld", {31'd0, vld16}, 32'd1);
      chk("b.hold", {16'd0, imm16}, 32'h0000_FF80);
      chk("b.cls", {30'd0, cls16}, 32'd2);
    end
    drive(1'b1, 16'h0A35, 1'b1, 1'b0);
    chk("b.rdy1", {31'd0, rdy16}, 32'd1);
    tick();
    chk("b.new", {16'd0, imm16}, 32'h0000_0005);
    chk("b.newcls", {30'd0, cls16}, 32'd0);
    chk("b.newvld", {31'd0, vld16}, 32'd1);

    // Flush drops the co-presented instruction and cancels the pending prefix
    expect_none("f0", 16'hF123);
    drive(1'b1, 16'h8005, 1'b1, 1'b1);
    tick();
    chk("f1.vld", {31'd0, vld16}, 32'd0);
    chk("f1.pfx", {31'd0, pfx16}, 32'd0);
    expect_out("f2", 16'h8005, 16'h0005, 32'h0000_0005, 2'b01, 1'b0);

    // Flush while stalled discards the held output
    drive(1'b0, 16'h0000, 1'b0, 1'b1);
    tick();
    chk("f3.vld", {31'd0, vld16}, 32'd0);
    flush = 1'b0;

    // Reset with a valid output, and reset clearing a pending prefix
    expect_out("r0", 16'hA080, 16'hFF80, 32'hFFFF_FF80, 2'b10, 1'b0);
    rst = 1'b1;
    drive(1'b1, 16'h0A35, 1'b0, 1'b0);
    tick();
    chk("r1.vld", {31'd0, vld16}, 32'd0);
    chk("r1.imm", {16'd0, imm16}, 32'd0);
    chk("r1.imm32", imm32, 32'd0);
    rst = 1'b0;
    expect_none("r2", 16'hF123);
    rst = 1'b1;
    drive(1'b0, 16'h0000, 1'b1, 1'b0);
    tick();
    rst = 1'b0;
    expect_out("r3", 16'h8005, 16'h0005, 32'h0000_0005, 2'b01, 1'b0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/imm_gen_pipe.md
Name: imm_gen_pipe

Overview:
- Next-generation immediate generator for the 16-bit core. It replaces the purely combinational extender.
- Adds a DATA_W-parametrised datapath and a one-stage registered valid/ready pipeline.
- Adds an immediate-prefix mechanism: a prefix instruction supplies upper immediate bits to the following instruction.
- Sits between the fetch/decode stage and the ALU/AGU/branch-target operand mux.

Parameters:
- DATA_W, 16, width of the produced immediate. Legal values are >= 16.
- PREFIX_EN, 1, enables prefix opcode handling. When 0, opcode 4'hF decodes as control.
- PREFIX_OPC, 4'hF, opcode of the prefix instruction. It is only meaningful when PREFIX_EN=1.

Ports:
- clk  input  1  system clock. All state updates on the rising edge.
- rst  input  1  synchronous, active-high reset.
- flush  input  1  synchronous pipeline flush (branch redirect).
- in_valid  input  1  instr is valid.
- in_ready  output  1  block accepts instr this cycle.
- instr  input  16  instruction word.
- out_valid  output  1  imm/imm_class valid.
- out_ready  input  1  consumer accepts output.
- imm  output  DATA_W  extended immediate.
- imm_class  output  2  00 compute, 01 mem-short, 10 mem-long, 11 control.
- out_prefixed  output  1  imm was built from a pending prefix.
- err_pfx_overwrite  output  1  one-cycle pulse: a pending prefix was overwritten by another prefix.

Behaviour:
- Reset (rst=1 at an edge) clears the following: out_valid=0, imm=0, imm_class=00, out_prefixed=0, err_pfx_overwrite=0, prefix register=0, FSM=NO_PFX.
  - rst overrides flush and in_valid.
  - Reset mid-transfer drops any held output and any pending prefix.
- Handshakes:
  - in_ready = !out_valid | out_ready (combinational). This holds in both FSM states.
  - Accept = in_valid & in_ready.
  - While out_valid=1 and out_ready=0, imm, imm_class and out_prefixed hold stable.
- Latency: a non-prefix instruction accepted at edge N presents out_valid=1 after edge N. That is one cycle, and full throughput of one instruction per cycle is sustained.
- Decode on instr[15:12], non-prefixed:
  - 0xxx: compute class, zero-extend instr[3:0].
  - 100x: mem-short class, sign-extend instr[3:0].
  - 101x: mem-long class, sign-extend instr[7:0].
  - 11xx, excluding PREFIX_OPC when PREFIX_EN=1: control class, sign-extend instr[8:0].
  - All extensions are to DATA_W.
- Prefix instruction (PREFIX_EN=1, opcode==PREFIX_OPC), when accepted:
  - Loads the 12-bit prefix register with instr[11:0].
  - FSM goes to PFX_PENDING.
  - Produces no output: out_valid is cleared if the current output is consumed, otherwise it is held.
- FSM states: NO_PFX and PFX_PENDING.
  - NO_PFX -> PFX_PENDING on prefix accept.
  - PFX_PENDING -> NO_PFX on non-prefix accept, flush, or rst.
  - PFX_PENDING with another prefix accept: stay in PFX_PENDING, overwrite the prefix register, pulse err_pfx_overwrite for one cycle.
- Prefixed result (non-prefix accept in PFX_PENDING):
  - Base value V = {prefix[11:0], instr[3:0]} (16 bits), for every class.
  - Compute class: V zero-extended to DATA_W.
  - Other classes: V sign-extended from bit 15 to DATA_W.
  - out_prefixed=1 and imm_class is set per opcode as above.
- flush (rst=0):
  - Clears out_valid and out_prefixed, and returns the FSM to NO_PFX.
  - An instruction presented in the same cycle is dropped: no output, no prefix load.
  - flush while out_ready=0 discards the held output.
- err_pfx_overwrite is 0 in every cycle except the one immediately following the overwriting accept.

Test Plan:
- Plain decode, DATA_W=16, out_ready=1: 0x0A35 -> imm 0x0005 class 00; 0x800F -> 0xFFFF class 01; 0xA080 -> 0xFF80 class 10; 0xC1FF -> 0xFFFF class 11; 0xC0FF -> 0x00FF. Each appears one cycle after accept, back-to-back, out_prefixed=0.
- Prefix, DATA_W=16: 0xF123 then 0x8005 -> no output for 0xF123; next output imm 0x1235, class 01, out_prefixed=1; FSM back to NO_PFX. Following 0x8005 -> 0x0005, out_prefixed=0.
- Prefix width, DATA_W=32: 0xFABC then 0x0007 -> 0x0000ABC7 (zero-extended). 0xFABC then 0xC003 -> 0xFFFFABC3.
- Double prefix: 0xF111, 0xF222, 0x8003 -> err_pfx_overwrite high exactly one cycle after the 0xF222 accept; final imm 0x2223, out_prefixed=1.
- Backpressure: output 0xFF80 with out_ready=0 for 3 cycles -> in_ready=0, imm held 0xFF80, later instr not accepted; out_ready=1 -> next instr accepted in the same cycle.
- Flush/reset: 0xF123 accepted, then flush together with in_valid on 0x8005 -> no output, FSM NO_PFX. Next 0x8005 -> 0x0005, out_prefixed=0. rst asserted with out_valid=1 -> out_valid=0, imm=0 after the edge.
